// File: rtl/cdb_arbiter_pkg.sv
// cdb_arbiter_pkg: shared source encodings, CDB payload type and round-robin helper
package cdb_arbiter_pkg;

  localparam int ROB_ENTRY_WIDTH = 4;
  localparam int CDB_DATA_WIDTH  = 32;

  localparam logic [1:0] CDB_SRC_ALU = 2'd0;
  localparam logic [1:0] CDB_SRC_LSQ = 2'd1;
  localparam logic [1:0] CDB_SRC_BRA = 2'd2;

  typedef struct packed {
    logic                       valid;
    logic [1:0]                 src;
    logic [ROB_ENTRY_WIDTH-1:0] rob_idx;
    logic [CDB_DATA_WIDTH-1:0]  data;
    logic                       jump_en;
    logic [31:0]                jump_addr;
  } cdb_pkt_t;

  // Successor of a source in the ALU -> LSQ -> BRA -> ALU ring.
  function automatic logic [1:0] rr_next(input logic [1:0] p);
    return (p >= CDB_SRC_BRA) ? CDB_SRC_ALU : p + 2'd1;
  endfunction

endpackage

// File: rtl/rr_arbiter3.sv
// rr_arbiter3: three-way round-robin grant with optional absolute priority for the branch source
module rr_arbiter3
  import cdb_arbiter_pkg::*;
(
  input  logic [2:0] req,
  input  logic [1:0] last,
  input  logic       prio_en,
  output logic [2:0] grant,
  output logic [1:0] grant_idx
);

  logic [1:0] p;
  logic       found;

  // Walk the ring starting after the last winner; with priority on, BRA is granted first and skipped in the ring.
  always_comb begin
    grant     = '0;
    grant_idx = CDB_SRC_ALU;
    found     = 1'b0;
    p         = rr_next(last);
    if (prio_en && req[CDB_SRC_BRA]) begin
      grant[CDB_SRC_BRA] = 1'b1;
      grant_idx          = CDB_SRC_BRA;
      found              = 1'b1;
    end
    for (int k = 0; k < 3; k++) begin
      if (!found && req[p] && !(prio_en && p == CDB_SRC_BRA)) begin
        grant[p]  = 1'b1;
        grant_idx = p;
        found     = 1'b1;
      end
      p = rr_next(p);
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: one-entry slots per execution unit arbitrated onto a registered CDB (CDB_BRA_PRIORITY_EN gives branches absolute priority)
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int IDX_W  = ROB_ENTRY_WIDTH,
  parameter int DATA_W = CDB_DATA_WIDTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rollback,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [IDX_W-1:0]  alu_rob_idx,
  input  logic [DATA_W-1:0] alu_data,
  input  logic              lsq_valid,
  output logic              lsq_ready,
  input  logic [IDX_W-1:0]  lsq_rob_idx,
  input  logic [DATA_W-1:0] lsq_data,
  input  logic              bra_valid,
  output logic              bra_ready,
  input  logic [IDX_W-1:0]  bra_rob_idx,
  input  logic [DATA_W-1:0] bra_data,
  input  logic              bra_jump_en,
  input  logic [31:0]       bra_jump_addr,
  output logic              cdb_valid,
  output logic [1:0]        cdb_src,
  output logic [IDX_W-1:0]  cdb_rob_idx,
  output logic [DATA_W-1:0] cdb_data,
  output logic              cdb_jump_en,
  output logic [31:0]       cdb_jump_addr
);

`ifdef CDB_BRA_PRIORITY_EN
  localparam logic PRIO_EN = 1'b1;
`else
  localparam logic PRIO_EN = 1'b0;
`endif

  typedef struct packed {
    logic [IDX_W-1:0]  rob_idx;
    logic [DATA_W-1:0] data;
  } slot_t;

  typedef struct packed {
    logic              valid;
    logic [1:0]        src;
    logic [IDX_W-1:0]  rob_idx;
    logic [DATA_W-1:0] data;
    logic              jump_en;
    logic [31:0]       jump_addr;
  } cdb_t;

  logic [2:0]  occ;
  logic [2:0]  in_valid;
  logic [2:0]  ready;
  logic [2:0]  grant;
  logic [1:0]  grant_idx;
  logic [1:0]  last;
  slot_t [2:0] slot;
  slot_t [2:0] in_pkt;
  logic        bra_jump_q;
  logic [31:0] bra_addr_q;
  cdb_t        cdb_d;
  cdb_t        cdb_q;

  assign in_valid  = {bra_valid, lsq_valid, alu_valid};
  assign in_pkt[0] = {alu_rob_idx, alu_data};
  assign in_pkt[1] = {lsq_rob_idx, lsq_data};
  assign in_pkt[2] = {bra_rob_idx, bra_data};

  // A slot accepts when empty or when it is draining onto the CDB this cycle.
  assign ready     = {3{~rollback}} & (~occ | grant);
  assign alu_ready = ready[0];
  assign lsq_ready = ready[1];
  assign bra_ready = ready[2];

  rr_arbiter3 u_arb (
    .req       (occ),
    .last      (last),
    .prio_en   (PRIO_EN),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  // Slot fill and drain; index 0 is accepted but leaves the slot empty.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      occ        <= '0;
      slot       <= '0;
      bra_jump_q <= 1'b0;
      bra_addr_q <= '0;
    end else if (rollback) begin
      occ <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (in_valid[i] && ready[i]) begin
          occ[i]  <= (in_pkt[i].rob_idx != '0);
          slot[i] <= in_pkt[i];
        end else if (grant[i]) begin
          occ[i] <= 1'b0;
        end
      end
      if (bra_valid && ready[2]) begin
        bra_jump_q <= bra_jump_en;
        bra_addr_q <= bra_jump_addr;
      end
    end
  end

  // Round-robin pointer follows real grants only; priority BRA grants and flushed cycles leave it alone.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      last <= CDB_SRC_BRA;
    else if (!rollback && |grant && !(PRIO_EN && grant_idx == CDB_SRC_BRA))
      last <= grant_idx;
  end

  // Next CDB word: the granted payload, or all zeros so the ROB sees index 0 as no-write.
  always_comb begin
    cdb_d = '0;
    if (!rollback && |grant) begin
      cdb_d.valid   = 1'b1;
      cdb_d.src     = grant_idx;
      cdb_d.rob_idx = slot[grant_idx].rob_idx;
      cdb_d.data    = slot[grant_idx].data;
      if (grant_idx == CDB_SRC_BRA) begin
        cdb_d.jump_en   = bra_jump_q;
        cdb_d.jump_addr = bra_addr_q;
      end
    end
  end

  // Registered broadcast.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      cdb_q <= '0;
    else
      cdb_q <= cdb_d;
  end

  assign cdb_valid     = cdb_q.valid;
  assign cdb_src       = cdb_q.src;
  assign cdb_rob_idx   = cdb_q.rob_idx;
  assign cdb_data      = cdb_q.data;
  assign cdb_jump_en   = cdb_q.jump_en;
  assign cdb_jump_addr = cdb_q.jump_addr;

endmodule
